// File: rtl/tsn_sched_pkg.sv
// Shared types and defaults for the TSN transmit stream scheduler.
package tsn_sched_pkg;

    localparam int N_STREAMS_DEF = 4;
    localparam int PEND_W_DEF    = 4;
    localparam int STAT_W        = 32;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQ       = 2'd1,
        WAIT_DONE = 2'd2
    } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at ptr and wraps modulo N.
module rr_arbiter #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    grant_oh,
    output logic [ID_W-1:0] grant_id,
    output logic            valid
);

    int idx;

    // Scan from the farthest offset down so the request nearest ptr wins last.
    always_comb begin
        idx      = 0;
        valid    = 1'b0;
        grant_id = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % N;
            if (req[idx[ID_W-1:0]]) begin
                valid    = 1'b1;
                grant_id = idx[ID_W-1:0];
            end
        end
        grant_oh = valid ? (N'(1) << grant_id) : '0;
    end

endmodule

// File: rtl/tx_stream_scheduler.sv
// Shares one frame generator among N periodic streams via pending-tick counters, round-robin
// arbitration and a req/ack/done handshake. Define TX_SCHED_STATS_EN for per-stream counters.
module tx_stream_scheduler
    import tsn_sched_pkg::*;
#(
    parameter int N_STREAMS = N_STREAMS_DEF,
    parameter int ID_W      = $clog2(N_STREAMS),
    parameter int PEND_W    = PEND_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sched_en,
    input  logic [N_STREAMS-1:0] stream_en,
    input  logic [N_STREAMS-1:0] tick,
    output logic                 tx_req,
    output logic [ID_W-1:0]      tx_stream_id,
    input  logic                 tx_ack,
    input  logic                 tx_done,
    output logic                 busy,
    output logic [N_STREAMS-1:0] drop_pulse
`ifdef TX_SCHED_STATS_EN
    ,
    input  logic [ID_W-1:0]      stat_sel,
    output logic [STAT_W-1:0]    stat_sent_cnt,
    output logic [STAT_W-1:0]    stat_drop_cnt
`endif
);

    localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

    sched_state_t         state_q, state_d;
    logic [ID_W-1:0]      id_q, id_d;
    logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [PEND_W-1:0]    pend_q [N_STREAMS];
    logic [PEND_W-1:0]    pend_d [N_STREAMS];
    logic [N_STREAMS-1:0] drop_pulse_q, drop_pulse_d;

    logic [N_STREAMS-1:0] req_vec, win_oh, grant_oh, tick_in;
    logic [ID_W-1:0]      win_id;
    logic                 win_valid, grant;

    rr_arbiter #(
        .N    (N_STREAMS),
        .ID_W (ID_W)
    ) u_rr_arbiter (
        .req      (req_vec),
        .ptr      (rr_ptr_q),
        .grant_oh (win_oh),
        .grant_id (win_id),
        .valid    (win_valid)
    );

    assign grant    = (state_q == IDLE) && sched_en && win_valid;
    assign grant_oh = grant ? win_oh : '0;

    // A tick and a grant in the same cycle cancel; a tick at saturation is dropped.
    for (genvar gi = 0; gi < N_STREAMS; gi++) begin : g_pend
        assign tick_in[gi]      = tick[gi] & stream_en[gi];
        assign req_vec[gi]      = stream_en[gi] && (pend_q[gi] != '0);
        assign drop_pulse_d[gi] = tick_in[gi] && !grant_oh[gi] && (pend_q[gi] == PEND_MAX);
        assign pend_d[gi] =
            !stream_en[gi]                                          ? '0 :
            (tick_in[gi] && !grant_oh[gi] && pend_q[gi] != PEND_MAX) ? pend_q[gi] + 1'b1 :
            (!tick_in[gi] && grant_oh[gi])                          ? pend_q[gi] - 1'b1 :
                                                                      pend_q[gi];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            id_q         <= '0;
            rr_ptr_q     <= '0;
            drop_pulse_q <= '0;
            for (int i = 0; i < N_STREAMS; i++) begin
                pend_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            id_q         <= id_d;
            rr_ptr_q     <= rr_ptr_d;
            drop_pulse_q <= drop_pulse_d;
            for (int i = 0; i < N_STREAMS; i++) begin
                pend_q[i] <= pend_d[i];
            end
        end
    end

    // Once issued, a request is held until acked regardless of the enables.
    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d  = REQ;
                    id_d     = win_id;
                    rr_ptr_d = (int'(win_id) == N_STREAMS - 1) ? '0 : win_id + 1'b1;
                end
            end
            REQ: begin
                if (tx_ack) begin
                    state_d = tx_done ? IDLE : WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (tx_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tx_req       = (state_q == REQ);
        busy         = (state_q != IDLE);
        tx_stream_id = id_q;
        drop_pulse   = drop_pulse_q;
    end

`ifdef TX_SCHED_STATS_EN
    logic [STAT_W-1:0] sent_cnt_q [N_STREAMS];
    logic [STAT_W-1:0] sent_cnt_d [N_STREAMS];
    logic [STAT_W-1:0] drop_cnt_q [N_STREAMS];
    logic [STAT_W-1:0] drop_cnt_d [N_STREAMS];
    logic [STAT_W-1:0] stat_sent_q, stat_sent_d, stat_drop_q, stat_drop_d;
    logic              ack_fire;

    assign ack_fire = (state_q == REQ) && tx_ack;

    for (genvar gi = 0; gi < N_STREAMS; gi++) begin : g_stats
        assign sent_cnt_d[gi] = sent_cnt_q[gi] + STAT_W'(ack_fire && (id_q == ID_W'(gi)));
        assign drop_cnt_d[gi] = drop_cnt_q[gi] + STAT_W'(drop_pulse_d[gi]);
    end

    always_comb begin
        stat_sent_d = '0;
        stat_drop_d = '0;
        if (int'(stat_sel) < N_STREAMS) begin
            stat_sent_d = sent_cnt_q[stat_sel];
            stat_drop_d = drop_cnt_q[stat_sel];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_sent_q <= '0;
            stat_drop_q <= '0;
            for (int i = 0; i < N_STREAMS; i++) begin
                sent_cnt_q[i] <= '0;
                drop_cnt_q[i] <= '0;
            end
        end else begin
            stat_sent_q <= stat_sent_d;
            stat_drop_q <= stat_drop_d;
            for (int i = 0; i < N_STREAMS; i++) begin
                sent_cnt_q[i] <= sent_cnt_d[i];
                drop_cnt_q[i] <= drop_cnt_d[i];
            end
        end
    end

    assign stat_sent_cnt = stat_sent_q;
    assign stat_drop_cnt = stat_drop_q;
`endif

endmodule

// File: tb/tb_tx_stream_scheduler.sv
// Directed self-checking bench for tx_stream_scheduler; stats section built with TX_SCHED_STATS_EN.
module tb_tx_stream_scheduler;

    logic        clk;
    logic        rst;
    logic        sched_en;
    logic [3:0]  stream_en;
    logic [3:0]  tick;
    logic        tx_req;
    logic [1:0]  tx_stream_id;
    logic        tx_ack;
    logic        tx_done;
    logic        busy;
    logic [3:0]  drop_pulse;
`ifdef TX_SCHED_STATS_EN
    logic [1:0]  stat_sel;
    logic [31:0] stat_sent_cnt;
    logic [31:0] stat_drop_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    tx_stream_scheduler #(
        .N_STREAMS (4),
        .ID_W      (2),
        .PEND_W    (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sched_en     (sched_en),
        .stream_en    (stream_en),
        .tick         (tick),
        .tx_req       (tx_req),
        .tx_stream_id (tx_stream_id),
        .tx_ack       (tx_ack),
        .tx_done      (tx_done),
        .busy         (busy),
        .drop_pulse   (drop_pulse)
`ifdef TX_SCHED_STATS_EN
        ,
        .stat_sel      (stat_sel),
        .stat_sent_cnt (stat_sent_cnt),
        .stat_drop_cnt (stat_drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #4 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, exp, $time);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Wait (bounded) for a request, check its id, then ack and finish it in the same cycle.
    task automatic serve(input logic [1:0] exp_id, input string tag);
        int waited = 0;
        while (!tx_req && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk({tag, "_req"}, tx_req, 1);
        chk({tag, "_id"}, tx_stream_id, exp_id);
        tx_ack  = 1'b1;
        tx_done = 1'b1;
        @(negedge clk);
        tx_ack  = 1'b0;
        tx_done = 1'b0;
        chk({tag, "_rel"}, tx_req, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        sched_en  = 1'b1;
        stream_en = 4'b1111;
        tick      = 4'b0000;
        tx_ack    = 1'b0;
        tx_done   = 1'b0;
`ifdef TX_SCHED_STATS_EN
        stat_sel  = 2'd0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_req", tx_req, 0);
        chk("rst_id", tx_stream_id, 0);
        chk("rst_busy", busy, 0);
        chk("rst_drop", drop_pulse, 0);
        rst = 1'b0;
        @(negedge clk);

        // Single stream, period 10, ack 1 cycle after req, done 5 after ack.
        for (int p = 0; p < 3; p++) begin
            tick = 4'b0001;
            @(negedge clk);
            tick = 4'b0000;
            chk("t1_pre", tx_req, 0);
            @(negedge clk);
            chk("t1_req", tx_req, 1);
            chk("t1_id", tx_stream_id, 0);
            tx_ack = 1'b1;
            @(negedge clk);
            tx_ack = 1'b0;
            chk("t1_wait", {tx_req, busy}, 2'b01);
            repeat (4) @(negedge clk);
            tx_done = 1'b1;
            @(negedge clk);
            tx_done = 1'b0;
            chk("t1_idle", busy, 0);
            chk("t1_drop", drop_pulse, 0);
            repeat (2) @(negedge clk);
        end

        // Round-robin order and pointer wrap.
        do_reset();
        tick = 4'b1111;
        @(negedge clk);
        tick = 4'b0000;
        serve(2'd0, "t2_a0");
        serve(2'd1, "t2_a1");
        serve(2'd2, "t2_a2");
        serve(2'd3, "t2_a3");
        tick = 4'b1100;
        @(negedge clk);
        tick = 4'b0000;
        serve(2'd2, "t2_b2");
        serve(2'd3, "t2_b3");
        tick = 4'b1001;
        @(negedge clk);
        tick = 4'b0000;
        serve(2'd0, "t2_c0");
        serve(2'd3, "t2_c3");
        repeat (3) @(negedge clk);
        chk("t2_idle", busy, 0);

        // Saturation: stream 0 stalls the generator, stream 1 ticks twenty times.
        do_reset();
        tick = 4'b0001;
        @(negedge clk);
        tick = 4'b0000;
        @(negedge clk);
        chk("t3_stall_req", tx_req, 1);
        for (int i = 0; i < 20; i++) begin
            tick = 4'b0010;
            @(negedge clk);
            tick = 4'b0000;
            chk($sformatf("t3_drop%0d", i), drop_pulse[1], (i >= 15) ? 1 : 0);
            @(negedge clk);
            chk($sformatf("t3_gap%0d", i), drop_pulse[1], 0);
        end
        chk("t3_held", {tx_req, tx_stream_id}, 3'b100);
        serve(2'd0, "t3_s0");
        for (int i = 0; i < 15; i++) begin
            serve(2'd1, $sformatf("t3_f%0d", i));
        end
        repeat (4) @(negedge clk);
        chk("t3_empty", busy, 0);

        // Disabling a stream while its request is outstanding.
        do_reset();
        tick = 4'b0100;
        repeat (3) @(negedge clk);
        tick = 4'b0000;
        chk("t4_req", {tx_req, tx_stream_id}, 3'b110);
        stream_en = 4'b1011;
        for (int i = 0; i < 3; i++) begin
            tick = (i == 1) ? 4'b0100 : 4'b0000;
            @(negedge clk);
            chk($sformatf("t4_hold%0d", i), {tx_req, tx_stream_id}, 3'b110);
        end
        tick = 4'b0000;
        tx_ack  = 1'b1;
        tx_done = 1'b1;
        @(negedge clk);
        tx_ack  = 1'b0;
        tx_done = 1'b0;
        stream_en = 4'b1111;
        repeat (6) @(negedge clk);
        chk("t4_no_regrant", busy, 0);

        // Asynchronous reset in WAIT_DONE with work still pending.
        do_reset();
        tick = 4'b0001;
        repeat (4) @(negedge clk);
        tick = 4'b0000;
        chk("t5_req", tx_req, 1);
        tx_ack = 1'b1;
        @(negedge clk);
        tx_ack = 1'b0;
        chk("t5_wait", {tx_req, busy}, 2'b01);
        #2 rst = 1'b1;
        #1 chk("t5_async", {tx_req, busy}, 2'b00);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("t5_cleared", busy, 0);
        tick = 4'b0001;
        @(negedge clk);
        tick = 4'b0000;
        @(negedge clk);
        chk("t5_newreq", tx_req, 1);
        #2 rst = 1'b1;
        #1 chk("t5_req_async", tx_req, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

`ifdef TX_SCHED_STATS_EN
        // Stream 3: two drops while stalled behind stream 0, then seven acked frames.
        do_reset();
        tick = 4'b0001;
        @(negedge clk);
        tick = 4'b0000;
        @(negedge clk);
        for (int i = 0; i < 17; i++) begin
            tick = 4'b1000;
            @(negedge clk);
            tick = 4'b0000;
            @(negedge clk);
        end
        serve(2'd0, "t6_s0");
        for (int i = 0; i < 7; i++) begin
            serve(2'd3, $sformatf("t6_f%0d", i));
        end
        stat_sel = 2'd3;
        repeat (2) @(negedge clk);
        chk("t6_sent3", stat_sent_cnt, 7);
        chk("t6_drop3", stat_drop_cnt, 2);
        stat_sel = 2'd0;
        @(negedge clk);
        chk("t6_sent0", stat_sent_cnt, 1);
        chk("t6_drop0", stat_drop_cnt, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
